// File: rtl/keypad_emulator.sv
// keypad_emulator: device side of a 4x4 row/column keypad with deterministic contact bounce
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 2000,
    parameter int BOUNCE_STEP   = 250,
    parameter int GAP_CYCLES    = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  Col,
    output logic [3:0]  Row,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [23:0] cmd_hold,
    output logic        busy,
    output logic        contact,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

    localparam logic [23:0] BOUNCE_LAST = 24'(BOUNCE_CYCLES - 1);
    localparam logic [23:0] STEP_LAST   = 24'(BOUNCE_STEP - 1);
    localparam logic [23:0] GAP_LAST    = 24'(GAP_CYCLES - 1);
    // nibble k holds {row bit, col bit} of key k; bit 3 is R1/C1
    localparam logic [63:0] KEY_MAP     = 64'h2104_8C56_79AB_DEF3;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d, step_q, step_d, hold_q, hold_d;
    logic [3:0]  key_q, key_d, row_q, row_d, kmap;
    logic        ph_q, ph_d, done_q, done_d, hit;

    // contact is derived from phase: ph_q counts completed bounce steps, hit flips the step in progress
    always_comb begin
        hit     = step_q == STEP_LAST;
        contact = state_q == HOLD
               || (state_q == BOUNCE_IN  && !(ph_q ^ hit))
               || (state_q == BOUNCE_OUT &&  (ph_q ^ hit));
        kmap    = KEY_MAP[{key_q, 2'b00} +: 4];
        row_d   = (contact && !Col[kmap[1:0]]) ? ~(4'b0001 << kmap[3:2]) : 4'b1111;
    end

    // command sequencing: accept, bounce in, hold, bounce out, gap, done
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 24'd1;
        step_d  = hit ? 24'd0 : step_q + 24'd1;
        ph_d    = ph_q ^ hit;
        key_d   = key_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                step_d = '0;
                ph_d   = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    key_d   = cmd_key;
                    hold_d  = (cmd_hold == '0) ? '0 : cmd_hold - 24'd1;
                    state_d = (BOUNCE_CYCLES == 0) ? HOLD : BOUNCE_IN;
                end
            end
            BOUNCE_IN: if (cnt_q == BOUNCE_LAST) begin
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: if (cnt_q == hold_q) begin
                cnt_d   = '0;
                step_d  = '0;
                ph_d    = 1'b0;
                state_d = (BOUNCE_CYCLES != 0) ? BOUNCE_OUT : (GAP_CYCLES != 0) ? GAP : IDLE;
                done_d  = BOUNCE_CYCLES == 0 && GAP_CYCLES == 0;
            end
            BOUNCE_OUT: if (cnt_q == BOUNCE_LAST) begin
                cnt_d   = '0;
                state_d = (GAP_CYCLES != 0) ? GAP : IDLE;
                done_d  = GAP_CYCLES == 0;
            end
            GAP: if (cnt_q == GAP_LAST) begin
                cnt_d   = '0;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset releases Row immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            ph_q    <= 1'b0;
            key_q   <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            row_q   <= 4'b1111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            ph_q    <= ph_d;
            key_q   <= key_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            row_q   <= row_d;
        end
    end

    assign Row       = row_q;
    assign done      = done_q;
    assign busy      = state_q != IDLE;
    assign cmd_ready = state_q == IDLE && rst_n;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: table, directed and randomized checks of the keypad emulator
module tb_keypad_emulator;
    localparam int CB = 7, CS = 3, CG = 0;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [3:0] a_col = '0, a_key = '0, a_row, b_col = '0, b_key = '0, b_row, c_col = '0, c_key = '0, c_row;
    logic [23:0] a_hold = '0, b_hold = '0, c_hold = '0;
    logic a_valid = 1'b0, a_ready, a_busy, a_contact, a_done;
    logic b_valid = 1'b0, b_ready, b_busy, b_contact, b_done;
    logic c_valid = 1'b0, c_ready, c_busy, c_contact, c_done;
    int n_pass = 0, n_tot = 0;

    typedef struct {
        logic [3:0]  key;
        logic [3:0]  col;
        logic [23:0] hold;
        logic [3:0]  row;
    } vec_t;

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_STEP(1), .GAP_CYCLES(4)) u_a (
        .clk(clk), .rst_n(rst_n), .Col(a_col), .Row(a_row), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_key(a_key), .cmd_hold(a_hold), .busy(a_busy), .contact(a_contact), .done(a_done));
    keypad_emulator #(.BOUNCE_CYCLES(8), .BOUNCE_STEP(2), .GAP_CYCLES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .Col(b_col), .Row(b_row), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_key(b_key), .cmd_hold(b_hold), .busy(b_busy), .contact(b_contact), .done(b_done));
    keypad_emulator #(.BOUNCE_CYCLES(CB), .BOUNCE_STEP(CS), .GAP_CYCLES(CG)) u_c (
        .clk(clk), .rst_n(rst_n), .Col(c_col), .Row(c_row), .cmd_valid(c_valid), .cmd_ready(c_ready),
        .cmd_key(c_key), .cmd_hold(c_hold), .busy(c_busy), .contact(c_contact), .done(c_done));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Row the scanner should see given the key, the column drive and the closure state
    function automatic logic [3:0] key_row(input logic [3:0] key, input logic [3:0] col, input logic closed);
        logic [3:0] grid [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
                                   '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'h0, 4'hF, 4'hE, 4'hD}};
        logic [3:0] r = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (grid[i][j] == key && closed && !col[3-j]) r[3-i] = 1'b0;
        return r;
    endfunction

    // one command on the no-bounce instance, called and returning on a falling edge
    task automatic run_a(input logic [3:0] key, input logic [3:0] col, input logic [23:0] hold, input logic [3:0] rexp);
        int h = (hold == 0) ? 1 : int'(hold);
        chk("a_ready_pre", a_ready, 1);
        a_valid = 1'b1; a_key = key; a_hold = hold; a_col = col;
        @(negedge clk);
        a_valid = 1'b0;
        for (int t = 1; t <= h + 6; t++) begin
            if (t > 1) @(negedge clk);
            chk("a_row", a_row, (t >= 2 && t <= h + 1) ? rexp : 4'hF);
            chk("a_busy", a_busy, t <= h + 4);
            chk("a_done", a_done, t == h + 5);
        end
    endtask

    initial begin
        vec_t vt[$];
        bit ec [0:26] = '{0, 1,0,0,1,1,0,0,1, 1,1,1,1,1,1, 0,1,1,0,0,1,1,0, 0,0, 0,0};
        bit q[$];
        logic m_done = 1'b0, cur;
        logic [3:0] m_row = 4'hF, m_key = 4'h0;
        vt = '{
            '{4'h5, 4'b1011, 24'd10, 4'b1011}, '{4'h5, 4'b0111, 24'd10, 4'b1111}, '{4'h5, 4'b0000, 24'd10, 4'b1011},
            '{4'h0, 4'b0111, 24'd2, 4'b1110},  '{4'h1, 4'b0111, 24'd2, 4'b0111},  '{4'h2, 4'b1011, 24'd2, 4'b0111},
            '{4'h3, 4'b1101, 24'd2, 4'b0111},  '{4'hA, 4'b1110, 24'd2, 4'b0111},  '{4'h4, 4'b0111, 24'd2, 4'b1011},
            '{4'h6, 4'b1101, 24'd2, 4'b1011},  '{4'hB, 4'b1110, 24'd2, 4'b1011},  '{4'h7, 4'b0111, 24'd2, 4'b1101},
            '{4'h8, 4'b1011, 24'd2, 4'b1101},  '{4'h9, 4'b1101, 24'd2, 4'b1101},  '{4'hC, 4'b1110, 24'd2, 4'b1101},
            '{4'hF, 4'b1011, 24'd2, 4'b1110},  '{4'hE, 4'b1101, 24'd2, 4'b1110},  '{4'hD, 4'b1110, 24'd0, 4'b1110},
            '{4'hD, 4'b1101, 24'd2, 4'b1111},  '{4'h1, 4'b1111, 24'd3, 4'b1111}};
        #1 rst_n = 1'b0;
        #2;
        chk("rst_row", a_row, 4'hF);
        chk("rst_contact", a_contact, 0);
        chk("rst_done", a_done, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", a_ready, 1);
        @(negedge clk);
        foreach (vt[i]) run_a(vt[i].key, vt[i].col, vt[i].hold, vt[i].row);

        // back-to-back: valid stays high, key 9 with hold 0 waits for the done cycle
        a_valid = 1'b1; a_key = 4'h3; a_hold = 24'd2; a_col = 4'b1101;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            chk("b2b_row", a_row, (t == 2 || t == 3) ? 4'b0111 : (t == 9) ? 4'b1101 : 4'hF);
            chk("b2b_contact", a_contact, t <= 2 || t == 8);
            chk("b2b_done", a_done, t == 7 || t == 13);
            chk("b2b_busy", a_busy, (t <= 6) || (t >= 8 && t <= 12));
            if (t == 7) chk("b2b_ready", a_ready, 1);
            if (t == 1) begin a_key = 4'h9; a_hold = 24'd0; end
            if (t == 8) a_valid = 1'b0;
        end

        // bounce pattern on key A
        chk("b_ready_pre", b_ready, 1);
        b_valid = 1'b1; b_key = 4'hA; b_hold = 24'd6; b_col = 4'b1110;
        @(negedge clk);
        b_valid = 1'b0;
        for (int t = 1; t <= 26; t++) begin
            if (t > 1) @(negedge clk);
            chk("bnc_contact", b_contact, ec[t]);
            chk("bnc_row3", b_row[3], !ec[t-1]);
            chk("bnc_row_rest", b_row[2:0], 3'b111);
            chk("bnc_done", b_done, t == 25);
            chk("bnc_busy", b_busy, t <= 24);
        end

        // randomized traffic against the timeline model
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            cur = (q.size() != 0) ? q[0] : 1'b0;
            chk("rnd_contact", c_contact, cur);
            chk("rnd_busy", c_busy, q.size() != 0);
            chk("rnd_ready", c_ready, q.size() == 0);
            chk("rnd_done", c_done, m_done);
            chk("rnd_row", c_row, m_row);
            c_valid = $urandom_range(0, 2) != 0;
            c_key = 4'($urandom);
            c_hold = 24'($urandom_range(0, 5));
            c_col = 4'($urandom);
            m_row = key_row(m_key, c_col, cur);
            m_done = q.size() == 1;
            if (q.size() != 0) void'(q.pop_front());
            else if (c_valid) begin
                m_key = c_key;
                for (int k = 0; k < CB; k++) q.push_back(1'b1 ^ (((k + 1) / CS) % 2 == 1));
                for (int k = 0; k < ((c_hold == 0) ? 1 : int'(c_hold)); k++) q.push_back(1'b1);
                for (int k = 0; k < CB; k++) q.push_back(((k + 1) / CS) % 2 == 1);
                for (int k = 0; k < CG; k++) q.push_back(1'b0);
            end
        end
        c_valid = 1'b0;

        // reset in the middle of a hold
        @(negedge clk);
        a_valid = 1'b1; a_key = 4'hD; a_hold = 24'd50; a_col = 4'b1110;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_row", a_row, 4'b1110);
        chk("mid_contact", a_contact, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_row", a_row, 4'hF);
        chk("abort_contact", a_contact, 0);
        chk("abort_busy", a_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort_ready", a_ready, 1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("abort_done", a_done, 0);
            chk("abort_row_idle", a_row, 4'hF);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
